// File: rtl/issue_scoreboard.sv
// Issue scoreboard: holds decoded instructions until their registers are
// hazard-free, caps in-flight work and serialises branches, FENCE and faults.
module issue_scoreboard #(
  parameter int MAX_INFLIGHT = 4,
  localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec_valid,
  output logic          dec_ready,
  input  logic [31:0]   dec_active_reg,
  input  logic [4:0]    dec_rd,
  input  logic [1:0]    dec_wb_op,
  input  logic [1:0]    dec_jmp_op,
  input  logic          dec_fault,
  input  logic          dec_fence,
  output logic          issue_valid,
  input  logic          retire_valid,
  input  logic          retire_wr,
  input  logic [4:0]    retire_rd,
  input  logic          redirect_valid,
  output logic [31:0]   busy_mask,
  output logic [CW-1:0] inflight,
  output logic [1:0]    state,
  output logic          fault_out,
  output logic          proto_err
);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_WAIT_BR = 2'd1;
  localparam logic [1:0] S_FENCE   = 2'd2;
  localparam logic [1:0] S_HALT    = 2'd3;

  localparam logic [31:0] X0_MASK = 32'hFFFF_FFFE;

  logic [31:0]   rmask;
  logic [31:0]   busy_eff;
  logic [31:0]   set_mask;
  logic          ret_dec;
  logic [CW-1:0] inf_eff;
  logic          hazard;
  logic          cap_ok;
  logic          drained;
  logic [1:0]    state_nxt;

  // Retires this cycle are visible to the hazard and cap checks (bypass).
  assign rmask = (retire_valid && retire_wr && retire_rd != 5'd0)
               ? (32'd1 << retire_rd) : 32'd0;
  assign busy_eff = busy_mask & ~rmask;
  assign ret_dec  = retire_valid && (inflight != '0);
  assign inf_eff  = inflight - CW'(ret_dec);
  assign hazard   = |(dec_active_reg & busy_eff & X0_MASK);
  assign cap_ok   = inf_eff < CW'(MAX_INFLIGHT);
  assign drained  = (inf_eff == '0) && (busy_eff == 32'd0);

  assign set_mask = (issue_valid && dec_wb_op != 2'd0 && dec_rd != 5'd0)
                  ? (32'd1 << dec_rd) : 32'd0;

  // Handshake and next-state decode; fault outranks fence and jump.
  always_comb begin
    dec_ready   = 1'b0;
    issue_valid = 1'b0;
    state_nxt   = state;
    unique case (state)
      S_RUN: begin
        if (dec_valid && dec_fault) begin
          state_nxt = S_HALT;
        end else if (dec_valid && dec_fence) begin
          state_nxt = S_FENCE;
        end else begin
          dec_ready   = !hazard && cap_ok;
          issue_valid = dec_valid && dec_ready;
          if (issue_valid && dec_jmp_op != 2'd0)
            state_nxt = S_WAIT_BR;
        end
      end
      S_WAIT_BR: begin
        if (redirect_valid)
          state_nxt = S_RUN;
      end
      S_FENCE: begin
        dec_ready = drained;
        if (drained && dec_valid)
          state_nxt = S_RUN;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
    endcase
  end

  // State, busy bits and counter; retires are processed in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      busy_mask <= 32'd0;
      inflight  <= '0;
      fault_out <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy_mask <= (busy_eff | set_mask) & X0_MASK;
      inflight  <= inf_eff + CW'(issue_valid);
      fault_out <= (state_nxt == S_HALT);
      if (retire_valid && inflight == '0)
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: vector table plus reset corner sequences.
// Registered expectations go through a queue and are checked after the edge.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_active_reg;
  logic [4:0]  dec_rd;
  logic [1:0]  dec_wb_op;
  logic [1:0]  dec_jmp_op;
  logic        dec_fault;
  logic        dec_fence;
  logic        issue_valid;
  logic        retire_valid;
  logic        retire_wr;
  logic [4:0]  retire_rd;
  logic        redirect_valid;
  logic [31:0] busy_mask;
  logic [2:0]  inflight;
  logic [1:0]  state;
  logic        fault_out;
  logic        proto_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  issue_scoreboard #(.MAX_INFLIGHT(4)) dut (
    .clk(clk),
    .rst(rst),
    .dec_valid(dec_valid),
    .dec_ready(dec_ready),
    .dec_active_reg(dec_active_reg),
    .dec_rd(dec_rd),
    .dec_wb_op(dec_wb_op),
    .dec_jmp_op(dec_jmp_op),
    .dec_fault(dec_fault),
    .dec_fence(dec_fence),
    .issue_valid(issue_valid),
    .retire_valid(retire_valid),
    .retire_wr(retire_wr),
    .retire_rd(retire_rd),
    .redirect_valid(redirect_valid),
    .busy_mask(busy_mask),
    .inflight(inflight),
    .state(state),
    .fault_out(fault_out),
    .proto_err(proto_err)
  );

  typedef struct {
    logic        v;
    logic [31:0] act;
    logic [4:0]  rd;
    logic [1:0]  wb;
    logic [1:0]  jmp;
    logic        flt;
    logic        fen;
    logic        rv;
    logic        rw;
    logic [4:0]  rrd;
    logic        redir;
    logic        rdy;
    logic        iss;
    logic [31:0] busy;
    logic [2:0]  inf;
    logic [1:0]  st;
    logic        fo;
    logic        pe;
  } vec_t;

  typedef struct {
    logic [31:0] busy;
    logic [2:0]  inf;
    logic [1:0]  st;
    logic        fo;
    logic        pe;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];

  function automatic vec_t mk(
    input logic v, input logic [31:0] act, input logic [4:0] rd,
    input logic [1:0] wb, input logic [1:0] jmp, input logic flt,
    input logic fen, input logic rv, input logic rw,
    input logic [4:0] rrd, input logic redir, input logic rdy,
    input logic iss, input logic [31:0] busy, input logic [2:0] inf,
    input logic [1:0] st, input logic fo, input logic pe);
    vec_t r;
    r.v = v; r.act = act; r.rd = rd; r.wb = wb; r.jmp = jmp;
    r.flt = flt; r.fen = fen; r.rv = rv; r.rw = rw; r.rrd = rrd;
    r.redir = redir; r.rdy = rdy; r.iss = iss; r.busy = busy;
    r.inf = inf; r.st = st; r.fo = fo; r.pe = pe;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic idle();
    dec_valid = 0; dec_active_reg = 0; dec_rd = 0; dec_wb_op = 0;
    dec_jmp_op = 0; dec_fault = 0; dec_fence = 0;
    retire_valid = 0; retire_wr = 0; retire_rd = 0;
    redirect_valid = 0;
  endtask

  task automatic apply(input vec_t r, input string tag);
    exp_t e;
    dec_valid = r.v; dec_active_reg = r.act; dec_rd = r.rd;
    dec_wb_op = r.wb; dec_jmp_op = r.jmp; dec_fault = r.flt;
    dec_fence = r.fen; retire_valid = r.rv; retire_wr = r.rw;
    retire_rd = r.rrd; redirect_valid = r.redir;
    #1;
    chk({tag, " dec_ready"}, 32'(dec_ready), 32'(r.rdy));
    chk({tag, " issue_valid"}, 32'(issue_valid), 32'(r.iss));
    e.busy = r.busy; e.inf = r.inf; e.st = r.st;
    e.fo = r.fo; e.pe = r.pe;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      total++; bad++;
      $display("FAIL %s queue: got empty want entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, " busy_mask"}, busy_mask, e.busy);
      chk({tag, " inflight"}, 32'(inflight), 32'(e.inf));
      chk({tag, " state"}, 32'(state), 32'(e.st));
      chk({tag, " fault_out"}, 32'(fault_out), 32'(e.fo));
      chk({tag, " proto_err"}, 32'(proto_err), 32'(e.pe));
    end
  endtask

  task automatic do_reset(input string tag);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk({tag, " busy_mask"}, busy_mask, 32'd0);
    chk({tag, " inflight"}, 32'(inflight), 32'd0);
    chk({tag, " state"}, 32'(state), 32'd0);
    chk({tag, " fault_out"}, 32'(fault_out), 32'd0);
    chk({tag, " proto_err"}, 32'(proto_err), 32'd0);
    chk({tag, " dec_ready"}, 32'(dec_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // RAW stall on x5, released by the x5 retire in the same cycle
    tbl.push_back(mk(1,32'h20,5,1,0,0,0,0,0,0,0, 1,1,32'h20,1,0,0,0));
    tbl.push_back(mk(1,32'h60,6,1,0,0,0,0,0,0,0, 0,0,32'h20,1,0,0,0));
    tbl.push_back(mk(1,32'h60,6,1,0,0,0,0,0,0,0, 0,0,32'h20,1,0,0,0));
    tbl.push_back(mk(1,32'h60,6,1,0,0,0,1,1,5,0, 1,1,32'h40,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,6,0, 1,0,0,0,0,0,0));
    // x0 writes never mark busy
    tbl.push_back(mk(1,32'h1,0,1,0,0,0,0,0,0,0, 1,1,0,1,0,0,0));
    tbl.push_back(mk(1,32'h1,0,0,0,0,0,0,0,0,0, 1,1,0,2,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,0,0, 1,0,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,0, 1,0,0,0,0,0,0));
    // in-flight cap
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 1,1,0,3'(i+1),0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,4,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,0,0,0, 1,1,0,4,0,0,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,0, 1,0,0,3'(3-i),0,0,0));
    // branch wait
    tbl.push_back(mk(1,0,0,0,2,0,0,0,0,0,0, 1,1,0,1,1,0,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,1,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,1, 0,0,0,1,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,0,0,0, 1,1,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,1, 1,0,0,0,0,0,0));
    // fence drain
    tbl.push_back(mk(1,32'h80,7,1,0,0,0,0,0,0,0, 1,1,32'h80,1,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 1,1,32'h80,2,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,1,0,0,0,0, 0,0,32'h80,2,2,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,1,0,0,0,0, 0,0,32'h80,2,2,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,1,1,1,7,0, 0,0,0,1,2,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,1,1,0,0,0, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0));
    // fault beats fence/jump, halt still retires, stray retire
    tbl.push_back(mk(1,32'h8,3,1,0,0,0,0,0,0,0, 1,1,32'h8,1,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,1,1,0,0,0,0, 0,0,32'h8,1,3,1,0));
    tbl.push_back(mk(1,0,0,0,0,1,0,1,1,3,0, 0,0,0,0,3,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,0, 0,0,0,0,3,1,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,3,1,1));

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    do_reset("reset");

    foreach (tbl[i])
      apply(tbl[i], $sformatf("row%0d", i));

    do_reset("halt_reset");

    // same rd retired and re-issued: set wins
    apply(mk(1,32'h200,9,1,0,0,0,0,0,0,0, 1,1,32'h200,1,0,0,0), "sbc0");
    apply(mk(1,32'h200,9,1,0,0,0,1,1,9,0, 1,1,32'h200,1,0,0,0), "sbc1");

    // reset mid-operation drops busy bits, count and branch wait
    apply(mk(1,32'h400,10,1,0,0,0,0,0,0,0, 1,1,32'h600,2,0,0,0), "mid0");
    apply(mk(1,0,0,0,1,0,0,0,0,0,0, 1,1,32'h600,3,1,0,0), "mid1");
    do_reset("mid_reset");
    apply(mk(1,32'h400,10,1,0,0,0,0,0,0,0, 1,1,32'h400,1,0,0,0), "post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
